alu_pipe_core: RTL and testbench
================================

// Module: alu_pipe_core
// PURPOSE
//  Parametrised, pipelined successor to the 4-bit combinational ALU.
//  Takes WIDTH-bit operands a/b and a 3-bit op under a valid/ready handshake.
//  Returns a registered result 2 edges after acceptance.
//  Adds OR/XOR ops, an internal accumulator with a sticky overflow flag, and a one-hot op decode on the output.
//  Sits between the operand sequencer and the result writeback.
// PARAMETERS
//  WIDTH  4  operand width in bits, >=2; result is WIDTH+1 bits
// PORTS
//  clk        in   1        rising-edge clock; the only clock
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        a/b/op valid this cycle
//  in_ready   out  1        block can accept; transfer when in_valid&&in_ready at edge
//  op         in   3        operation select (see BEHAVIOUR)
//  a          in   WIDTH    operand A (unsigned)
//  b          in   WIDTH    operand B (unsigned)
//  out_valid  out  1        result/cmp/op_dec valid
//  out_ready  in   1        consumer takes result when out_valid&&out_ready at edge
//  result     out  WIDTH+1  operation result
//  cmp        out  3        {gt,eq,lt} of a vs b for the output transaction, any op
//  op_dec     out  8        one-hot of output transaction's op; 0 when out_valid=0
//  acc_ovf    out  1        sticky accumulator overflow flag
// BEHAVIOUR
//  Reset (sync, rst=1 at edge): S1/S2 valid=0, acc=0, acc_ovf=0, result=0, cmp=0, op_dec=0.
//   In-flight transactions are discarded, not completed.
//   in_ready=1 in the cycle after reset.
//  Pipeline: S1 registers {op,a,b}; S2 computes and registers outputs.
//   advance = !out_valid || out_ready; in_ready = advance (combinational).
//   When advance=1: S1<=input (valid=in_valid), S2<=f(S1) (valid=S1 valid).
//   When advance=0: S1, S2 and acc hold; outputs stable while out_valid&&!out_ready.
//  Latency: accepted at edge k -> out_valid high after edge k+1 if not stalled.
//   Throughput 1/cycle when out_ready=1. No bubbles are inserted; order is preserved.
//  Ops (WIDTH-bit unsigned; result zero-extended unless stated):
//   000 ADD     result = a+b, bit WIDTH = carry
//   001 SUB     result = {borrow, (a-b) mod 2^WIDTH}, borrow = (a<b)
//   010 CMP     result = {0.., gt,eq,lt}
//   011 AND     result = a&b
//   100 OR      result = a|b
//   101 XOR     result = a^b
//   110 ACC_ADD acc <= (acc+a) mod 2^WIDTH; acc_ovf <= acc_ovf | carry;
//               result = {carry, new acc}; b ignored except for cmp
//   111 ACC_CLR result = {0, old acc}; acc <= 0; acc_ovf <= 0
//  acc and acc_ovf update only on the S1->S2 advance of an ACC op, in order.
//   Back-to-back ACC ops each see the previous op's acc.
//  cmp is exactly one-hot for every valid output.
//  op_dec = 1<<op of the S2 transaction when out_valid=1.
//  Inputs are don't-care when in_valid=0; a bubble never touches acc.
// TESTING
//  WIDTH=4, rst 2 cycles -> out_valid=0, in_ready=1, acc_ovf=0, result=0.
//  ADD a=0011 b=1001 -> result=01100, cmp=001, op_dec=00000001; 2 edges after accept.
//  SUB a=0101 b=1100 -> result=11001; CMP a=1101 b=1101 -> result=00010, cmp=010.
//  ACC_ADD a=0111 x3 back-to-back -> results 00111, 01110, 10101; acc_ovf=1.
//   Then ACC_CLR -> result=00101, acc_ovf=0.
//  Stall: out_ready=0 with 2 ops in flight -> in_ready=0 and outputs stable.
//   Release out_ready -> both ops delivered in order on consecutive cycles.
//  rst asserted with ACC ops in flight -> no output delivered.
//   Next ACC_ADD a=0001 -> result=00001.

Source files
------------

// File: rtl/alu_pipe_if.sv
// Operand/result bus of the pipelined ALU: operand handshake in, result handshake out.
// Handshake: a beat transfers on a rising edge where valid && ready; the source holds
// its payload until that edge, and ready may depend combinationally on downstream ready.
interface alu_pipe_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   result;
  logic [2:0]       cmp;
  logic [7:0]       op_dec;
  logic             acc_ovf;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, cmp, op_dec, acc_ovf
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, cmp, op_dec, acc_ovf
  );
endinterface

// File: rtl/alu_pipe_core.sv
// Two-stage pipelined ALU: S1 captures {op,a,b}, S2 computes and registers the result,
// with an in-order accumulator and sticky overflow flag.
module alu_pipe_core #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  alu_pipe_if.slave  bus
);
  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_CMP     = 3'b010;
  localparam logic [2:0] OP_AND     = 3'b011;
  localparam logic [2:0] OP_OR      = 3'b100;
  localparam logic [2:0] OP_XOR     = 3'b101;
  localparam logic [2:0] OP_ACC_ADD = 3'b110;
  localparam logic [2:0] OP_ACC_CLR = 3'b111;

  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             s2_valid;
  logic [2:0]       s2_op;
  logic [WIDTH:0]   s2_result;
  logic [2:0]       s2_cmp;

  logic [WIDTH-1:0] acc;
  logic             acc_ovf_q;

  logic             advance;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   acc_sum;
  logic [WIDTH:0]   f_result;
  logic [2:0]       f_cmp;
  logic [WIDTH-1:0] acc_next;
  logic             ovf_next;

  // The whole pipe moves as one unit; a stalled S2 freezes S1 and the accumulator too.
  assign advance = !s2_valid || bus.out_ready;

  always_comb begin
    f_cmp    = {s1_a > s1_b, s1_a == s1_b, s1_a < s1_b};
    sum      = {1'b0, s1_a} + {1'b0, s1_b};
    diff     = {1'b0, s1_a} - {1'b0, s1_b};
    acc_sum  = {1'b0, acc} + {1'b0, s1_a};
    f_result = '0;
    acc_next = acc;
    ovf_next = acc_ovf_q;
    case (s1_op)
      OP_ADD: f_result = sum;
      OP_SUB: f_result = {s1_a < s1_b, diff[WIDTH-1:0]};
      OP_CMP: f_result[2:0] = f_cmp;
      OP_AND: f_result = {1'b0, s1_a & s1_b};
      OP_OR:  f_result = {1'b0, s1_a | s1_b};
      OP_XOR: f_result = {1'b0, s1_a ^ s1_b};
      OP_ACC_ADD: begin
        f_result = acc_sum;
        acc_next = acc_sum[WIDTH-1:0];
        ovf_next = acc_ovf_q | acc_sum[WIDTH];
      end
      OP_ACC_CLR: begin
        f_result = {1'b0, acc};
        acc_next = '0;
        ovf_next = 1'b0;
      end
      default: f_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s2_valid  <= 1'b0;
      s2_op     <= '0;
      s2_result <= '0;
      s2_cmp    <= '0;
      acc       <= '0;
      acc_ovf_q <= 1'b0;
    end else if (advance) begin
      s1_valid <= bus.in_valid;
      s1_op    <= bus.op;
      s1_a     <= bus.a;
      s1_b     <= bus.b;
      s2_valid <= s1_valid;
      // Bubbles leave S2 data and the accumulator untouched.
      if (s1_valid) begin
        s2_op     <= s1_op;
        s2_result <= f_result;
        s2_cmp    <= f_cmp;
        acc       <= acc_next;
        acc_ovf_q <= ovf_next;
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = s2_valid;
  assign bus.result    = s2_result;
  assign bus.cmp       = s2_cmp;
  assign bus.op_dec    = s2_valid ? (8'b1 << s2_op) : 8'b0;
  assign bus.acc_ovf   = acc_ovf_q;
endmodule

// File: tb/tb_alu_pipe_core.sv
// Directed bench for alu_pipe_core at WIDTH=4: inputs driven and outputs checked on negedges.
module tb_alu_pipe_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  alu_pipe_if #(.WIDTH(4)) bus ();

  alu_pipe_core #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one operand beat now and move to the next negedge (accepted if in_ready was 1).
  task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.op = 3'b000;
    bus.a = 4'h0;
    bus.b = 4'h0;
  endtask

  initial begin
    idle();
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_acc_ovf",   32'(bus.acc_ovf),   32'd0);
    chk("rst_result",    32'(bus.result),    32'h00);
    chk("rst_op_dec",    32'(bus.op_dec),    32'h00);
    chk("rst_cmp",       32'(bus.cmp),       32'h0);

    // ADD 3+9: one edge after accept nothing yet, second edge delivers.
    issue(3'b000, 4'b0011, 4'b1001);
    idle();
    chk("add_lat_early", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("add_valid",  32'(bus.out_valid), 32'd1);
    chk("add_result", 32'(bus.result),    32'h0C);
    chk("add_cmp",    32'(bus.cmp),       32'b001);
    chk("add_op_dec", 32'(bus.op_dec),    32'h01);
    @(negedge clk);
    chk("add_drain_valid",  32'(bus.out_valid), 32'd0);
    chk("add_drain_op_dec", 32'(bus.op_dec),    32'h00);

    // SUB then CMP back-to-back.
    issue(3'b001, 4'b0101, 4'b1100);
    issue(3'b010, 4'b1101, 4'b1101);
    idle();
    chk("sub_result", 32'(bus.result), 32'h19);
    chk("sub_cmp",    32'(bus.cmp),    32'b001);
    chk("sub_op_dec", 32'(bus.op_dec), 32'h02);
    @(negedge clk);
    chk("cmp_valid",  32'(bus.out_valid), 32'd1);
    chk("cmp_result", 32'(bus.result),    32'h02);
    chk("cmp_cmp",    32'(bus.cmp),       32'b010);
    chk("cmp_op_dec", 32'(bus.op_dec),    32'h04);
    @(negedge clk);

    // Logic ops streamed at full rate.
    issue(3'b011, 4'b1100, 4'b1010);
    issue(3'b100, 4'b1100, 4'b1010);
    chk("and_result", 32'(bus.result), 32'h08);
    chk("and_cmp",    32'(bus.cmp),    32'b100);
    chk("and_op_dec", 32'(bus.op_dec), 32'h08);
    issue(3'b101, 4'b1100, 4'b1010);
    idle();
    chk("or_result", 32'(bus.result), 32'h0E);
    chk("or_op_dec", 32'(bus.op_dec), 32'h10);
    @(negedge clk);
    chk("xor_result", 32'(bus.result), 32'h06);
    chk("xor_op_dec", 32'(bus.op_dec), 32'h20);
    @(negedge clk);

    // Accumulator: 7, 14, 21 -> 5 with carry; then clear.
    issue(3'b110, 4'b0111, 4'b0000);
    issue(3'b110, 4'b0111, 4'b0000);
    chk("acc1_result", 32'(bus.result),  32'h07);
    chk("acc1_ovf",    32'(bus.acc_ovf), 32'd0);
    chk("acc1_cmp",    32'(bus.cmp),     32'b100);
    issue(3'b110, 4'b0111, 4'b0000);
    idle();
    chk("acc2_result", 32'(bus.result),  32'h0E);
    chk("acc2_ovf",    32'(bus.acc_ovf), 32'd0);
    @(negedge clk);
    chk("acc3_result", 32'(bus.result),  32'h15);
    chk("acc3_ovf",    32'(bus.acc_ovf), 32'd1);
    chk("acc3_op_dec", 32'(bus.op_dec),  32'h40);
    issue(3'b111, 4'b0000, 4'b0000);
    idle();
    chk("ovf_sticky", 32'(bus.acc_ovf), 32'd1);
    @(negedge clk);
    chk("clr_result", 32'(bus.result),  32'h05);
    chk("clr_ovf",    32'(bus.acc_ovf), 32'd0);
    chk("clr_op_dec", 32'(bus.op_dec),  32'h80);
    @(negedge clk);

    // Stall with two ops in flight; an offered beat during the stall must be refused.
    bus.out_ready = 1'b0;
    issue(3'b000, 4'd1, 4'd2);
    issue(3'b000, 4'd3, 4'd4);
    idle();
    chk("stall_in_ready", 32'(bus.in_ready),  32'd0);
    chk("stall_result0",  32'(bus.result),    32'h03);
    issue(3'b000, 4'hF, 4'hF);
    issue(3'b000, 4'hF, 4'hF);
    idle();
    chk("stall_valid",   32'(bus.out_valid), 32'd1);
    chk("stall_result1", 32'(bus.result),    32'h03);
    chk("stall_ready1",  32'(bus.in_ready),  32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_valid",  32'(bus.out_valid), 32'd1);
    chk("release_result", 32'(bus.result),    32'h07);
    @(negedge clk);
    chk("release_drain", 32'(bus.out_valid), 32'd0);

    // Reset with ACC ops in flight discards them and clears the accumulator.
    issue(3'b110, 4'd3, 4'd0);
    rst = 1'b1;
    bus.a = 4'd4;
    @(negedge clk);
    rst = 1'b0;
    idle();
    chk("rst_flight_valid0", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("rst_flight_valid1", 32'(bus.out_valid), 32'd0);
    issue(3'b110, 4'b0001, 4'b0000);
    idle();
    @(negedge clk);
    chk("post_rst_valid",  32'(bus.out_valid), 32'd1);
    chk("post_rst_result", 32'(bus.result),    32'h01);
    chk("post_rst_ovf",    32'(bus.acc_ovf),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
